// File: rtl/sync_counter_pkg.sv
// Shared constants and helpers for the synchronous T-flip-flop up-counter.
// Optional feature macro: SYNC_UPCOUNTER_MODULO_EN (modulo-MOD_N counting).
package sync_counter_pkg;

  localparam int             COUNT_W       = 4;
  localparam logic [3:0]     COUNT_MAX     = 4'hF;
  localparam int             MOD_N_DEFAULT = 10;

  // Terminal count value: MOD_N-1 in modulo mode, all-ones otherwise.
  function automatic logic [COUNT_W-1:0] count_max_f(input logic mod_en, input int mod_n);
    logic [COUNT_W-1:0] max_v;
    if (mod_en) begin
      max_v = COUNT_W'(mod_n - 1);
    end else begin
      max_v = COUNT_MAX;
    end
    return max_v;
  endfunction

endpackage

// File: rtl/sync_tff_upcounter_if.sv
// Control and count-output bundle of the T-flip-flop up-counter.
// master = controller driving en/load/d, slave = counter.
interface sync_tff_upcounter_if;
  import sync_counter_pkg::*;

  logic               en;
  logic               load;
  logic [COUNT_W-1:0] d;
  logic               q1;
  logic               q2;
  logic               q3;
  logic               q4;
  logic               tc;

  modport master (
    output en, load, d,
    input  q1, q2, q3, q4, tc
  );

  modport slave (
    input  en, load, d,
    output q1, q2, q3, q4, tc
  );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-low reset.
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic rst_n,
  output logic q
);

  // Toggle on a rising edge when t is high; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/sync_tff_upcounter.sv
// 4-bit synchronous up-counter built from four commonly clocked T flip-flops.
// Priority per edge: reset > load > en > hold. tc is combinational.
// Optional feature macro: SYNC_UPCOUNTER_MODULO_EN -- count modulo MOD_N;
// without it the counter is a plain modulo-16 binary counter and MOD_N is unused
// apart from folding into a constant.
module sync_tff_upcounter
  import sync_counter_pkg::*;
#(
  parameter int MOD_N = MOD_N_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  sync_tff_upcounter_if.slave bus
);

`ifdef SYNC_UPCOUNTER_MODULO_EN
  localparam logic [COUNT_W-1:0] MAX_C = count_max_f(1'b1, MOD_N);
`else
  localparam logic [COUNT_W-1:0] MAX_C = count_max_f(1'b0, MOD_N);
`endif

  logic [COUNT_W-1:0] q_s;
  logic [COUNT_W-1:0] t_s;
  logic [COUNT_W-1:0] inc_t_s;

  // Binary increment toggles: bit i flips when all lower bits are one.
  assign inc_t_s = {q_s[0] & q_s[1] & q_s[2], q_s[0] & q_s[1], q_s[0], 1'b1};

  // Toggle inputs: load copies d (T = q ^ d), en increments, else hold.
  always_comb begin
    t_s = {COUNT_W{1'b0}};
    if (bus.load) begin
      t_s = q_s ^ bus.d;
    end else if (bus.en) begin
`ifdef SYNC_UPCOUNTER_MODULO_EN
      // At or beyond the modulo limit (e.g. after an out-of-range load), T = q clears to 0.
      if (q_s >= MAX_C) begin
        t_s = q_s;
      end else begin
        t_s = inc_t_s;
      end
`else
      t_s = inc_t_s;
`endif
    end else begin
      t_s = {COUNT_W{1'b0}};
    end
  end

  // Four flip-flops share clk and reset; no ripple clocking.
  for (genvar i = 0; i < COUNT_W; i++) begin : g_cell
    tff_cell u_tff (
      .t     (t_s[i]),
      .clk   (clk),
      .rst_n (reset),
      .q     (q_s[i])
    );
  end

  assign bus.q1 = q_s[0];
  assign bus.q2 = q_s[1];
  assign bus.q3 = q_s[2];
  assign bus.q4 = q_s[3];

  // Terminal count only when an increment (not a load) is pending at the maximum.
  assign bus.tc = bus.en & ~bus.load & (q_s == MAX_C);

endmodule

// File: tb/tb_sync_tff_upcounter.sv
// Directed self-checking bench for sync_tff_upcounter.
// Covers the default build; the modulo scenario is compiled in only when
// SYNC_UPCOUNTER_MODULO_EN is defined.
module tb_sync_tff_upcounter;
  import sync_counter_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sync_tff_upcounter_if bus_if ();

  sync_tff_upcounter #(.MOD_N(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] cnt();
    return {bus_if.q4, bus_if.q3, bus_if.q2, bus_if.q1};
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_if.en = 1'b1; bus_if.load = 1'b0; bus_if.d = 4'h0;
    #2;
    checks++;
    if (cnt() !== 4'b0000 || bus_if.tc !== 1'b0) begin
      failures++;
      $display("FAIL reset_t0 got cnt=%b tc=%b want cnt=0000 tc=0", cnt(), bus_if.tc);
    end
    tick(); tick();
    checks++;
    if (cnt() !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held got %b want 0000", cnt());
    end
    reset = 1'b1;
    tick();
    checks++;
    if (cnt() !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_edge got %b want 0001", cnt());
    end
    tick();
    checks++;
    if (cnt() !== 4'b0010) begin
      failures++;
      $display("FAIL reset_second_edge got %b want 0010", cnt());
    end
  endtask

  task automatic test_wrap16();
    bus_if.load = 1'b1; bus_if.d = 4'h0; bus_if.en = 1'b1;
    tick();
    bus_if.load = 1'b0;
    checks++;
    if (cnt() !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_start got %b want 0000", cnt());
    end
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (cnt() !== 4'b1111 || bus_if.tc !== 1'b1) begin
          failures++;
          $display("FAIL wrap_max got cnt=%b tc=%b want cnt=1111 tc=1", cnt(), bus_if.tc);
        end
      end else if (i == 14) begin
        checks++;
        if (cnt() !== 4'b1110 || bus_if.tc !== 1'b0) begin
          failures++;
          $display("FAIL wrap_pre_max got cnt=%b tc=%b want cnt=1110 tc=0", cnt(), bus_if.tc);
        end
      end else if (i == 16) begin
        checks++;
        if (cnt() !== 4'b0000 || bus_if.tc !== 1'b0) begin
          failures++;
          $display("FAIL wrap_zero got cnt=%b tc=%b want cnt=0000 tc=0", cnt(), bus_if.tc);
        end
      end else if (i == 17) begin
        checks++;
        if (cnt() !== 4'b0001) begin
          failures++;
          $display("FAIL wrap_one got %b want 0001", cnt());
        end
      end
    end
    // At maximum with en low, tc must stay low.
    bus_if.load = 1'b1; bus_if.d = 4'hF;
    tick();
    bus_if.load = 1'b0; bus_if.en = 1'b0;
    #1;
    checks++;
    if (cnt() !== 4'b1111 || bus_if.tc !== 1'b0) begin
      failures++;
      $display("FAIL tc_en_low got cnt=%b tc=%b want cnt=1111 tc=0", cnt(), bus_if.tc);
    end
  endtask

  task automatic test_hold();
    bus_if.load = 1'b1; bus_if.d = 4'b1001; bus_if.en = 1'b0;
    tick();
    bus_if.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (cnt() !== 4'b1001 || bus_if.tc !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d got cnt=%b tc=%b want cnt=1001 tc=0", i, cnt(), bus_if.tc);
      end
    end
    bus_if.en = 1'b1;
    tick();
    checks++;
    if (cnt() !== 4'b1010) begin
      failures++;
      $display("FAIL hold_resume got %b want 1010", cnt());
    end
  endtask

  task automatic test_load();
    // Park at 1111 with en high, then load: tc must be suppressed by load.
    bus_if.load = 1'b1; bus_if.d = 4'hF; bus_if.en = 1'b1;
    tick();
    bus_if.d = 4'b0110;
    #1;
    checks++;
    if (bus_if.tc !== 1'b0) begin
      failures++;
      $display("FAIL load_tc got %b want 0", bus_if.tc);
    end
    tick();
    checks++;
    if (cnt() !== 4'b0110) begin
      failures++;
      $display("FAIL load_value got %b want 0110", cnt());
    end
    bus_if.load = 1'b0;
    tick();
    checks++;
    if (cnt() !== 4'b0111) begin
      failures++;
      $display("FAIL load_then_inc got %b want 0111", cnt());
    end
  endtask

  task automatic test_async_reset();
    bus_if.load = 1'b1; bus_if.d = 4'b1011; bus_if.en = 1'b1;
    tick();
    bus_if.load = 1'b0;
    checks++;
    if (cnt() !== 4'b1011) begin
      failures++;
      $display("FAIL areset_setup got %b want 1011", cnt());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (cnt() !== 4'b0000 || bus_if.tc !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate got cnt=%b tc=%b want cnt=0000 tc=0", cnt(), bus_if.tc);
    end
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if (cnt() !== 4'b0001) begin
      failures++;
      $display("FAIL areset_resume got %b want 0001", cnt());
    end
    // Reset held across an edge overrides a pending load.
    bus_if.load = 1'b1; bus_if.d = 4'b0101;
    reset = 1'b0;
    tick();
    checks++;
    if (cnt() !== 4'b0000) begin
      failures++;
      $display("FAIL areset_over_load got %b want 0000", cnt());
    end
    reset = 1'b1; bus_if.load = 1'b0;
  endtask

`ifdef SYNC_UPCOUNTER_MODULO_EN
  task automatic test_modulo();
    bus_if.load = 1'b1; bus_if.d = 4'h0; bus_if.en = 1'b1;
    tick();
    bus_if.load = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      logic [3:0] exp_v;
      logic       exp_tc;
      tick();
      exp_v  = (i == 10) ? 4'd0 : 4'(i);
      exp_tc = (i == 9) ? 1'b1 : 1'b0;
      checks++;
      if (cnt() !== exp_v || bus_if.tc !== exp_tc) begin
        failures++;
        $display("FAIL mod_step_%0d got cnt=%b tc=%b want cnt=%b tc=%b", i, cnt(), bus_if.tc, exp_v, exp_tc);
      end
    end
    bus_if.load = 1'b1; bus_if.d = 4'b1100;
    tick();
    bus_if.load = 1'b0;
    #1;
    checks++;
    if (cnt() !== 4'b1100 || bus_if.tc !== 1'b0) begin
      failures++;
      $display("FAIL mod_oor_load got cnt=%b tc=%b want cnt=1100 tc=0", cnt(), bus_if.tc);
    end
    tick();
    checks++;
    if (cnt() !== 4'b0000) begin
      failures++;
      $display("FAIL mod_oor_wrap got %b want 0000", cnt());
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    test_reset();
`ifdef SYNC_UPCOUNTER_MODULO_EN
    test_modulo();
`else
    test_wrap16();
`endif
    test_hold();
    test_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_tff_upcounter.md
SYNC_TFF_UPCOUNTER -- requirements
Module: sync_tff_upcounter

Interface
REQ-001 Parameter: MOD_N, default 10, modulus used only when SYNC_UPCOUNTER_MODULO_EN is defined; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: en  input  1  count enable; high = increment on next rising edge.
REQ-005 Port: load  input  1  synchronous parallel-load strobe.
REQ-006 Port: d  input  4  parallel-load value; d[0] = LSB.
REQ-007 Port: q1  output  1  count bit 0 (LSB).
REQ-008 Port: q2  output  1  count bit 1.
REQ-009 Port: q3  output  1  count bit 2.
REQ-010 Port: q4  output  1  count bit 3 (MSB).
REQ-011 Port: tc  output  1  terminal count; combinational; high when en = 1, load = 0 and count = maximum value.

Function
REQ-012 Count value SHALL be {q4,q3,q2,q1}, held in four T flip-flops clocked together on clk rising edge; no ripple clocking.
REQ-013 Toggle inputs, increment: T1 = 1, T2 = q1, T3 = q1&q2, T4 = q1&q2&q3, all gated by en.
REQ-014 Priority per edge: reset > load > en > hold.
REQ-015 load = 1: count SHALL equal d after that edge, whatever en is; toggle input Ti = qi XOR d[i-1].
REQ-016 load = 0, en = 1: count SHALL increment by 1 at that edge; latency one edge, no pipeline.
REQ-017 load = 0, en = 0: all T inputs SHALL be 0; count held indefinitely.
REQ-018 Maximum value: 4'b1111 without the macro; MOD_N-1 with the macro.
REQ-019 Wrap: increment from maximum value SHALL give 4'b0000 on the same edge; tc high in the cycle before the wrap.
REQ-020 tc SHALL be 0 whenever en = 0 or load = 1.
REQ-021 en or load changing between edges SHALL have no effect until the next rising edge.

Reset
REQ-022 reset = 0 SHALL force q1..q4 = 0 immediately, with no clock required; tc then 0.
REQ-023 Reset asserted mid-count SHALL override load and en; counting resumes from 0 at the first rising edge after reset = 1.
REQ-024 Reset deassertion SHALL be synchronised by the integrator; the block adds no deassertion synchroniser.

Configuration
REQ-025 Macro SYNC_UPCOUNTER_MODULO_EN defined: counter SHALL be modulo MOD_N; increment at count MOD_N-1 loads 0 (T = q) instead of toggling normally.
REQ-026 With macro, a loaded value >= MOD_N SHALL be held as loaded; the next increment SHALL give 0, and tc SHALL stay 0 while at that value.
REQ-027 Macro undefined: plain modulo-16 binary counter; MOD_N ignored; no compare logic synthesised.

Structure
REQ-028 Shared package sync_counter_pkg SHALL hold COUNT_W = 4, count-max constant 4'hF and the MOD_N default 10.
REQ-029 One sub-module, tff_cell (T, clk, active-low async reset -> q), SHALL be instantiated four times; all next-state logic stays in sync_tff_upcounter.

Verification
REQ-030 reset = 0 at t = 0 with en = 1, then reset = 1 -> count 0000 while in reset; 0001 after the first edge; 0010 after the second.
REQ-031 en = 1 for 17 edges from 0000 -> 1111 reached with tc = 1 in that cycle; 0000 after the 16th edge; 0001 after the 17th.
REQ-032 Count at 1001, en = 0 for 2 edges, then en = 1 -> count holds 1001 for 2 edges with tc = 0; then 1010.
REQ-033 load = 1, d = 0110, en = 1 -> count 0110 after the edge (no increment); load = 0 -> 0111 next edge.
REQ-034 reset pulsed low between edges at count 1011 -> q = 0000 within the same cycle, before any edge; count 0001 after the first edge following release with en = 1.
REQ-035 With SYNC_UPCOUNTER_MODULO_EN and MOD_N = 10 -> sequence 0..9 then 0, tc = 1 at 1001; load d = 1100, en = 1 -> 1100, then 0000.
